data_cache_port_arbiter: RTL and testbench

DATA_CACHE_PORT_ARBITER -- requirements
Module: data_cache_port_arbiter

---
 rtl/data_memory_pkg.sv | 37 +++
 rtl/data_cache_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_data_cache_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared types and constants for the data-memory subsystem.
//   PORT_WIDTH / PORT_BYTES   : width of the cache data port and its byte lanes
//   data_cache_addr_t         : byte address presented to the data cache
//   data_cache_enable_t       : per-bank enable vector
//   data_cache_arb_fsm_t      : port arbiter state encoding
//   data_cache_requester_t    : identifies the refill / load / store controllers
// -----------------------------------------------------------------------------
package data_memory_pkg;

    localparam int PORT_WIDTH   = 32;
    localparam int PORT_BYTES   = PORT_WIDTH / 8;
    localparam int ADDR_WIDTH   = 32;
    localparam int ENABLE_WIDTH = 4;

    typedef logic [ADDR_WIDTH-1:0]   data_cache_addr_t;
    typedef logic [ENABLE_WIDTH-1:0] data_cache_enable_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_RF = 2'd1,
        GRANT_LD = 2'd2,
        GRANT_ST = 2'd3
    } data_cache_arb_fsm_t;

    typedef enum logic [1:0] {
        REQ_RF = 2'd0,
        REQ_LD = 2'd1,
        REQ_ST = 2'd2
    } data_cache_requester_t;

    // Encoding of the 1-bit load/store round-robin history register.
    localparam logic LAST_LD = 1'b0;
    localparam logic LAST_ST = 1'b1;

endpackage

// File: rtl/data_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// data_cache_port_arbiter
// Arbitrates the single data-cache port between the refill, load and store
// controllers. Refill has absolute priority; load and store alternate when both
// ask. The owner keeps the port until it raises done or holds it for
// TIMEOUT_CYCLES cycles, after which the port is forcibly released. Every
// release passes through IDLE, so there is always one bubble between owners.
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   {rf,ld,st}_req_i / _done_i        request / release from each controller
//   {rf,ld,st}_grant_o                registered one-hot (or zero) grant
//   {rf,ld,st}_{write,read,dirty,valid}_i, _address_i, _byte_write_i,
//   _data_i, _enable_i                per-requester cache control and data
//   cache_*_o                         owner's signals forwarded to the cache
//   timeout_o                         one-cycle pulse on forced release
//   idle_o                            high while no requester owns the port
// -----------------------------------------------------------------------------
module data_cache_port_arbiter
    import data_memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    rf_req_i,
    input  logic                    ld_req_i,
    input  logic                    st_req_i,
    input  logic                    rf_done_i,
    input  logic                    ld_done_i,
    input  logic                    st_done_i,
    output logic                    rf_grant_o,
    output logic                    ld_grant_o,
    output logic                    st_grant_o,

    input  logic                    rf_write_i,
    input  logic                    rf_read_i,
    input  logic                    rf_dirty_i,
    input  logic                    rf_valid_i,
    input  data_cache_addr_t        rf_address_i,
    input  logic [PORT_BYTES-1:0]   rf_byte_write_i,
    input  logic [PORT_WIDTH-1:0]   rf_data_i,
    input  data_cache_enable_t      rf_enable_i,

    input  logic                    ld_write_i,
    input  logic                    ld_read_i,
    input  logic                    ld_dirty_i,
    input  logic                    ld_valid_i,
    input  data_cache_addr_t        ld_address_i,
    input  logic [PORT_BYTES-1:0]   ld_byte_write_i,
    input  logic [PORT_WIDTH-1:0]   ld_data_i,
    input  data_cache_enable_t      ld_enable_i,

    input  logic                    st_write_i,
    input  logic                    st_read_i,
    input  logic                    st_dirty_i,
    input  logic                    st_valid_i,
    input  data_cache_addr_t        st_address_i,
    input  logic [PORT_BYTES-1:0]   st_byte_write_i,
    input  logic [PORT_WIDTH-1:0]   st_data_i,
    input  data_cache_enable_t      st_enable_i,

    output logic                    cache_write_o,
    output logic                    cache_read_o,
    output logic                    cache_dirty_o,
    output logic                    cache_valid_o,
    output data_cache_addr_t        cache_address_o,
    output logic [PORT_BYTES-1:0]   cache_byte_write_o,
    output logic [PORT_WIDTH-1:0]   cache_data_o,
    output data_cache_enable_t      cache_enable_o,

    output logic                    timeout_o,
    output logic                    idle_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    data_cache_arb_fsm_t state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q;
    logic                last_served_q, last_served_d;
    logic                owner_done;
    logic                force_release;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            last_served_q <= LAST_ST;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            // The count is held at zero in IDLE, so it is always clear on
            // entry to a grant state; it saturates rather than wrapping.
            if (state_q == IDLE)
                hold_cnt_q <= '0;
            else if (!owner_done && hold_cnt_q != CNT_MAX)
                hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        owner_done    = 1'b0;
        force_release = 1'b0;

        case (state_q)
            GRANT_RF: owner_done = rf_done_i;
            GRANT_LD: owner_done = ld_done_i;
            GRANT_ST: owner_done = st_done_i;
            default:  owner_done = 1'b0;
        endcase

        // done in the final allowed cycle wins over the timeout.
        force_release = (state_q != IDLE) && !owner_done && (hold_cnt_q == CNT_LAST);

        if (state_q == IDLE) begin
            if (rf_req_i) begin
                state_d = GRANT_RF;
            end else if (ld_req_i && (!st_req_i || last_served_q == LAST_ST)) begin
                state_d       = GRANT_LD;
                last_served_d = LAST_LD;
            end else if (st_req_i) begin
                state_d       = GRANT_ST;
                last_served_d = LAST_ST;
            end
        end else if (owner_done || force_release) begin
            state_d = IDLE;
        end
    end

    assign rf_grant_o = (state_q == GRANT_RF);
    assign ld_grant_o = (state_q == GRANT_LD);
    assign st_grant_o = (state_q == GRANT_ST);
    assign idle_o     = (state_q == IDLE);
    assign timeout_o  = force_release;

    always_comb begin
        cache_write_o      = 1'b0;
        cache_read_o       = 1'b0;
        cache_dirty_o      = 1'b0;
        cache_valid_o      = 1'b0;
        cache_address_o    = '0;
        cache_byte_write_o = '0;
        cache_data_o       = '0;
        cache_enable_o     = '0;
        case (state_q)
            GRANT_RF: begin
                cache_write_o      = rf_write_i;
                cache_read_o       = rf_read_i;
                cache_dirty_o      = rf_dirty_i;
                cache_valid_o      = rf_valid_i;
                cache_address_o    = rf_address_i;
                cache_byte_write_o = rf_byte_write_i;
                cache_data_o       = rf_data_i;
                cache_enable_o     = rf_enable_i;
            end
            GRANT_LD: begin
                cache_write_o      = ld_write_i;
                cache_read_o       = ld_read_i;
                cache_dirty_o      = ld_dirty_i;
                cache_valid_o      = ld_valid_i;
                cache_address_o    = ld_address_i;
                cache_byte_write_o = ld_byte_write_i;
                cache_data_o       = ld_data_i;
                cache_enable_o     = ld_enable_i;
            end
            GRANT_ST: begin
                cache_write_o      = st_write_i;
                cache_read_o       = st_read_i;
                cache_dirty_o      = st_dirty_i;
                cache_valid_o      = st_valid_i;
                cache_address_o    = st_address_i;
                cache_byte_write_o = st_byte_write_i;
                cache_data_o       = st_data_i;
                cache_enable_o     = st_enable_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_cache_port_arbiter.sv
module tb_data_cache_port_arbiter;
    import data_memory_pkg::*;

    localparam int T = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic rf_req_i = 0, ld_req_i = 0, st_req_i = 0;
    logic rf_done_i = 0, ld_done_i = 0, st_done_i = 0;
    logic rf_grant_o, ld_grant_o, st_grant_o;
    logic rf_write_i = 0, rf_read_i = 0, rf_dirty_i = 0, rf_valid_i = 0;
    logic ld_write_i = 0, ld_read_i = 0, ld_dirty_i = 0, ld_valid_i = 0;
    logic st_write_i = 0, st_read_i = 0, st_dirty_i = 0, st_valid_i = 0;
    data_cache_addr_t rf_address_i = 0, ld_address_i = 0, st_address_i = 0;
    logic [PORT_BYTES-1:0] rf_byte_write_i = 0, ld_byte_write_i = 0, st_byte_write_i = 0;
    logic [PORT_WIDTH-1:0] rf_data_i = 0, ld_data_i = 0, st_data_i = 0;
    data_cache_enable_t rf_enable_i = 0, ld_enable_i = 0, st_enable_i = 0;
    logic cache_write_o, cache_read_o, cache_dirty_o, cache_valid_o;
    data_cache_addr_t cache_address_o;
    logic [PORT_BYTES-1:0] cache_byte_write_o;
    logic [PORT_WIDTH-1:0] cache_data_o;
    data_cache_enable_t cache_enable_o;
    logic timeout_o, idle_o;

    int n_cmp = 0;
    int n_fail = 0;

    data_cache_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rf_req_i(rf_req_i), .ld_req_i(ld_req_i), .st_req_i(st_req_i),
        .rf_done_i(rf_done_i), .ld_done_i(ld_done_i), .st_done_i(st_done_i),
        .rf_grant_o(rf_grant_o), .ld_grant_o(ld_grant_o), .st_grant_o(st_grant_o),
        .rf_write_i(rf_write_i), .rf_read_i(rf_read_i), .rf_dirty_i(rf_dirty_i), .rf_valid_i(rf_valid_i),
        .rf_address_i(rf_address_i), .rf_byte_write_i(rf_byte_write_i), .rf_data_i(rf_data_i), .rf_enable_i(rf_enable_i),
        .ld_write_i(ld_write_i), .ld_read_i(ld_read_i), .ld_dirty_i(ld_dirty_i), .ld_valid_i(ld_valid_i),
        .ld_address_i(ld_address_i), .ld_byte_write_i(ld_byte_write_i), .ld_data_i(ld_data_i), .ld_enable_i(ld_enable_i),
        .st_write_i(st_write_i), .st_read_i(st_read_i), .st_dirty_i(st_dirty_i), .st_valid_i(st_valid_i),
        .st_address_i(st_address_i), .st_byte_write_i(st_byte_write_i), .st_data_i(st_data_i), .st_enable_i(st_enable_i),
        .cache_write_o(cache_write_o), .cache_read_o(cache_read_o), .cache_dirty_o(cache_dirty_o), .cache_valid_o(cache_valid_o),
        .cache_address_o(cache_address_o), .cache_byte_write_o(cache_byte_write_o), .cache_data_o(cache_data_o),
        .cache_enable_o(cache_enable_o), .timeout_o(timeout_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 = nobody, 1 = refill, 2 = load, 3 = store.
    int m_owner = 0;
    int m_held  = 0;      // completed grant cycles of the current owner
    bit m_ld_last = 1'b0; // load won the most recent ld/st contest

    function automatic bit req_of(int who);
        return (who == 1) ? rf_req_i : (who == 2) ? ld_req_i : (who == 3) ? st_req_i : 1'b0;
    endfunction

    function automatic bit done_of(int who);
        return (who == 1) ? rf_done_i : (who == 2) ? ld_done_i : (who == 3) ? st_done_i : 1'b0;
    endfunction

    function automatic logic [75:0] port_of(int who);
        case (who)
            1: return {rf_write_i, rf_read_i, rf_dirty_i, rf_valid_i, rf_address_i, rf_byte_write_i, rf_data_i, rf_enable_i};
            2: return {ld_write_i, ld_read_i, ld_dirty_i, ld_valid_i, ld_address_i, ld_byte_write_i, ld_data_i, ld_enable_i};
            3: return {st_write_i, st_read_i, st_dirty_i, st_valid_i, st_address_i, st_byte_write_i, st_data_i, st_enable_i};
            default: return '0;
        endcase
    endfunction

    function automatic bit exp_timeout();
        return (m_owner != 0) && !done_of(m_owner) && (m_held + 1 == T);
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_owner   <= 0;
            m_held    <= 0;
            m_ld_last <= 1'b0;
        end else if (m_owner == 0) begin
            m_held <= 0;
            if (req_of(1)) m_owner <= 1;
            else if (req_of(2) || req_of(3)) begin
                // prefer whichever of ld/st did not win last, if it is asking
                automatic int pick = (req_of(2) && req_of(3)) ? (m_ld_last ? 3 : 2) : (req_of(2) ? 2 : 3);
                m_owner   <= pick;
                m_ld_last <= (pick == 2);
            end
        end else if (done_of(m_owner) || exp_timeout()) begin
            m_owner <= 0;
        end else begin
            m_held <= m_held + 1;
        end
    end

    always @(negedge clk_i) begin
        chk("grants", {rf_grant_o, ld_grant_o, st_grant_o},
            {m_owner == 1, m_owner == 2, m_owner == 3});
        chk("idle", idle_o, m_owner == 0);
        chk("timeout", timeout_o, exp_timeout());
        chk("cache_port",
            {cache_write_o, cache_read_o, cache_dirty_o, cache_valid_o, cache_address_o,
             cache_byte_write_o, cache_data_o, cache_enable_o},
            port_of(m_owner));
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rf_address_i = 32'h0000_0100; rf_data_i = 32'h1111_1111; rf_byte_write_i = 4'b1111;
        rf_enable_i = 4'h1; rf_write_i = 1; rf_valid_i = 1;
        ld_address_i = 32'h0000_0200; ld_data_i = 32'h2222_2222; ld_byte_write_i = 4'b0011;
        ld_enable_i = 4'h2; ld_read_i = 1; ld_valid_i = 1;
        st_address_i = 32'h0000_0300; st_data_i = 32'h3333_3333; st_byte_write_i = 4'b0101;
        st_enable_i = 4'h4; st_write_i = 1; st_dirty_i = 1;

        #1 rst_i = 1'b1;
        #1;
        chk("reset_idle", idle_o, 1'b1);
        chk("reset_grants", {rf_grant_o, ld_grant_o, st_grant_o}, 3'b000);
        step(1);
        rst_i = 1'b0;

        // all three request together: rf, then ld, then st
        rf_req_i = 1; ld_req_i = 1; st_req_i = 1;
        step(1);
        chk("all3_rf_first", {rf_grant_o, ld_grant_o, st_grant_o}, 3'b100);
        chk("all3_rf_data", cache_data_o, 32'h1111_1111);
        rf_done_i = 1; rf_req_i = 0;
        step(1);
        chk("all3_bubble1", idle_o, 1'b1);
        rf_done_i = 0;
        step(1);
        chk("all3_ld_second", {rf_grant_o, ld_grant_o, st_grant_o}, 3'b010);
        ld_done_i = 1; ld_req_i = 0;
        step(1);
        chk("all3_bubble2", idle_o, 1'b1);
        ld_done_i = 0;
        step(1);
        chk("all3_st_third", {rf_grant_o, ld_grant_o, st_grant_o}, 3'b001);
        st_done_i = 1; st_req_i = 0;
        step(1);
        chk("all3_bubble3", idle_o, 1'b1);
        st_done_i = 0;

        // ld and st both held: alternate ld, st, ld, st
        ld_req_i = 1; st_req_i = 1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("rr_owner", {ld_grant_o, st_grant_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
            step(1);
            if (i % 2 == 0) ld_done_i = 1; else st_done_i = 1;
            if (i == 3) begin ld_req_i = 0; st_req_i = 0; end
            step(1);
            chk("rr_bubble", idle_o, 1'b1);
            ld_done_i = 0; st_done_i = 0;
        end

        // store owns the port; load activity must not disturb it
        st_address_i = 32'h0000_0040; st_byte_write_i = 4'b1100; st_data_i = 32'hDEAD_BEEF;
        st_write_i = 1; st_read_i = 0; st_dirty_i = 0; st_valid_i = 1; st_enable_i = 4'hF;
        st_req_i = 1;
        step(1);
        chk("st_grant", st_grant_o, 1'b1);
        chk("st_addr", cache_address_o, 32'h0000_0040);
        chk("st_bw", cache_byte_write_o, 4'b1100);
        chk("st_data", cache_data_o, 32'hDEAD_BEEF);
        chk("st_write", cache_write_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ld_req_i = k[0];
            ld_done_i = (k == 1);
            ld_data_i = $urandom;
            ld_address_i = $urandom;
            if (k >= 2) st_req_i = 0;
            step(1);
            chk("st_kept", {rf_grant_o, ld_grant_o, st_grant_o}, 3'b001);
            chk("st_data_kept", cache_data_o, 32'hDEAD_BEEF);
        end
        ld_done_i = 0; ld_req_i = 0;

        // asynchronous reset in the middle of the store grant
        #2 rst_i = 1'b1;
        #1;
        chk("arst_write", cache_write_o, 1'b0);
        chk("arst_data", cache_data_o, 32'h0);
        chk("arst_idle", idle_o, 1'b1);
        chk("arst_grants", {rf_grant_o, ld_grant_o, st_grant_o}, 3'b000);
        st_req_i = 0;
        step(1);
        rst_i = 1'b0;

        // load never finishes: forced release after T cycles
        ld_req_i = 1;
        step(1);
        for (int k = 1; k <= T; k++) begin
            chk("to_hold", ld_grant_o, 1'b1);
            chk("to_pulse", timeout_o, k == T);
            if (k == T) ld_req_i = 0;
            else step(1);
        end
        step(1);
        chk("to_idle", idle_o, 1'b1);
        chk("to_pulse_gone", timeout_o, 1'b0);

        // done in the last allowed cycle wins over the timeout
        ld_req_i = 1;
        step(1);
        step(T - 1);
        ld_done_i = 1; ld_req_i = 0;
        #1;
        chk("done_vs_to_grant", ld_grant_o, 1'b1);
        chk("done_vs_to_pulse", timeout_o, 1'b0);
        step(1);
        chk("done_vs_to_idle", idle_o, 1'b1);
        ld_done_i = 0;

        // lone load wins even though load was served last; then contest goes to st
        ld_req_i = 1;
        step(1);
        chk("lone_ld", {ld_grant_o, st_grant_o}, 2'b10);
        ld_done_i = 1;
        step(1);
        ld_done_i = 0; st_req_i = 1;
        step(1);
        chk("contest_st", {ld_grant_o, st_grant_o}, 2'b01);
        st_done_i = 1; ld_req_i = 0; st_req_i = 0;
        step(1);
        st_done_i = 0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
